eeg_oram_rd_ctrl: RTL and testbench

EEG_ORAM_RD_CTRL -- requirements
Module: eeg_oram_rd_ctrl

---
 rtl/eeg_oram_rd_ctrl.sv | 144 ++++++++++++++
 tb/tb_eeg_oram_rd_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeg_oram_rd_ctrl.sv
// Read controller for one ORAM bank.
// A job is a base address and a word count. The controller issues
// (base + index) read requests under credit control, then collects the
// returned words in a small FIFO and streams them downstream. DONE pulses
// for one cycle after the word tagged last is accepted downstream.
// Ports:
//   clk, rst                          : clock and synchronous active-high reset
//   CFG_VLD/CFG_RDY, CFG_BASE, CFG_LEN: job command
//   ORAM_ADD_*                        : read-address request channel
//   ORAM_DAT_*                        : read-data return channel (fixed 1-cycle latency)
//   OUT_*                             : downstream stream
//   BUSY, DONE                        : job status
module eeg_oram_rd_ctrl #(
  parameter int unsigned ORAM_ADD_MW    = 8,
  parameter int unsigned ORAM_DAT_DW    = 8,
  parameter int unsigned OUT_FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   CFG_VLD,
  output logic                   CFG_RDY,
  input  logic [ORAM_ADD_MW-1:0] CFG_BASE,
  input  logic [ORAM_ADD_MW:0]   CFG_LEN,
  output logic                   ORAM_ADD_VLD,
  output logic                   ORAM_ADD_LST,
  input  logic                   ORAM_ADD_RDY,
  output logic [ORAM_ADD_MW-1:0] ORAM_ADD_ADD,
  input  logic                   ORAM_DAT_VLD,
  input  logic                   ORAM_DAT_LST,
  output logic                   ORAM_DAT_RDY,
  input  logic [ORAM_DAT_DW-1:0] ORAM_DAT_DAT,
  output logic                   OUT_VLD,
  output logic                   OUT_LST,
  input  logic                   OUT_RDY,
  output logic [ORAM_DAT_DW-1:0] OUT_DAT,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam int unsigned LW = ORAM_ADD_MW + 1;
  localparam int unsigned PW = $clog2(OUT_FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                 state;
  logic [ORAM_ADD_MW-1:0] base;
  logic [LW-1:0]          len;
  logic [LW-1:0]          idx;
  logic                   inflight;
  logic                   done_q;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic [ORAM_DAT_DW:0]   mem [OUT_FIFO_DEPTH];

  logic                   credit;
  logic                   add_vld;
  logic                   add_hs;
  logic                   last_idx;
  logic [ORAM_ADD_MW-1:0] add_addr;
  logic                   push;
  logic                   pop;
  logic                   out_vld;
  logic [ORAM_DAT_DW:0]   head;

  // The word requested last cycle is not yet in count, so it holds a credit.
  assign credit   = (count + CW'(inflight)) < CW'(OUT_FIFO_DEPTH);
  assign add_vld  = (state == ISSUE) && credit;
  assign add_hs   = add_vld && ORAM_ADD_RDY;
  assign last_idx = (idx == (len - LW'(1)));
  assign add_addr = base + idx[ORAM_ADD_MW-1:0];
  assign push     = ORAM_DAT_VLD && inflight;
  assign out_vld  = (count != '0);
  assign pop      = out_vld && OUT_RDY;
  assign head     = mem[rd_ptr];

  // Job FSM, issue index and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      base     <= '0;
      len      <= '0;
      idx      <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      done_q   <= 1'b0;
      inflight <= add_hs;
      case (state)
        IDLE: begin
          if (CFG_VLD) begin
            base <= CFG_BASE;
            len  <= CFG_LEN;
            idx  <= '0;
            if (CFG_LEN == '0) done_q <= 1'b1;
            else               state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (add_hs) begin
            idx <= idx + LW'(1);
            if (last_idx) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && head[ORAM_DAT_DW]) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: {last flag, data}.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ORAM_DAT_LST, ORAM_DAT_DAT};
  end

  // Outputs are forced quiet while reset is held.
  assign CFG_RDY      = rst || (state == IDLE);
  assign ORAM_DAT_RDY = !rst;
  assign ORAM_ADD_VLD = !rst && add_vld;
  assign ORAM_ADD_LST = !rst && add_vld && last_idx;
  assign ORAM_ADD_ADD = rst ? '0 : add_addr;
  assign OUT_VLD      = !rst && out_vld;
  assign OUT_LST      = !rst && out_vld && head[ORAM_DAT_DW];
  assign OUT_DAT      = rst ? '0 : head[ORAM_DAT_DW-1:0];
  assign BUSY         = !rst && (state != IDLE);
  assign DONE         = !rst && done_q;

endmodule

// File: tb/tb_eeg_oram_rd_ctrl.sv
// Directed testbench for eeg_oram_rd_ctrl with a 1-cycle ORAM responder
// whose read data is (address ^ 8'h5A).
module tb_eeg_oram_rd_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_vld;
  logic       cfg_rdy;
  logic [7:0] cfg_base;
  logic [8:0] cfg_len;
  logic       add_vld, add_lst, add_rdy;
  logic [7:0] add_add;
  logic       dat_vld, dat_lst, dat_rdy;
  logic [7:0] dat_dat;
  logic       out_vld, out_lst, out_rdy;
  logic [7:0] out_dat;
  logic       busy, done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] add_log[$];
  logic       addl_log[$];
  logic [7:0] out_log[$];
  logic       outl_log[$];

  eeg_oram_rd_ctrl #(.ORAM_ADD_MW(8), .ORAM_DAT_DW(8), .OUT_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .CFG_VLD(cfg_vld), .CFG_RDY(cfg_rdy), .CFG_BASE(cfg_base), .CFG_LEN(cfg_len),
    .ORAM_ADD_VLD(add_vld), .ORAM_ADD_LST(add_lst), .ORAM_ADD_RDY(add_rdy), .ORAM_ADD_ADD(add_add),
    .ORAM_DAT_VLD(dat_vld), .ORAM_DAT_LST(dat_lst), .ORAM_DAT_RDY(dat_rdy), .ORAM_DAT_DAT(dat_dat),
    .OUT_VLD(out_vld), .OUT_LST(out_lst), .OUT_RDY(out_rdy), .OUT_DAT(out_dat),
    .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: log handshakes mid-cycle, then apply the ORAM response after the edge.
  task automatic tick();
    logic       hs;
    logic [7:0] a;
    logic       l;
    @(negedge clk);
    hs = add_vld & add_rdy;
    a  = add_add;
    l  = add_lst;
    if (hs) begin
      add_log.push_back(a);
      addl_log.push_back(l);
    end
    if (out_vld & out_rdy) begin
      out_log.push_back(out_dat);
      outl_log.push_back(out_lst);
    end
    @(posedge clk);
    #1;
    dat_vld = hs;
    dat_dat = a ^ 8'h5A;
    dat_lst = l;
  endtask

  task automatic clear_logs();
    add_log.delete();
    addl_log.delete();
    out_log.delete();
    outl_log.delete();
  endtask

  // Present a job for one cycle; returns in cycle T+1.
  task automatic cfg(input logic [7:0] b, input logic [8:0] l);
    cfg_vld  = 1'b1;
    cfg_base = b;
    cfg_len  = l;
    tick();
    cfg_vld  = 1'b0;
  endtask

  task automatic run_until_done(input int max_cyc);
    int n = 0;
    while (!done && n < max_cyc) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done), 1);
  endtask

  task automatic chk_out(input string tag, input int i, input logic [7:0] d, input logic l);
    if (i < out_log.size()) begin
      chk({tag, "_dat"}, 32'(out_log[i]), 32'(d));
      chk({tag, "_lst"}, 32'(outl_log[i]), 32'(l));
    end else begin
      chk({tag, "_missing"}, 32'(out_log.size()), 32'(i + 1));
    end
  endtask

  task automatic chk_add(input string tag, input int i, input logic [7:0] a, input logic l);
    if (i < add_log.size()) begin
      chk({tag, "_add"}, 32'(add_log[i]), 32'(a));
      chk({tag, "_lst"}, 32'(addl_log[i]), 32'(l));
    end else begin
      chk({tag, "_missing"}, 32'(add_log.size()), 32'(i + 1));
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    cfg_vld = 1'b0; cfg_base = '0; cfg_len = '0;
    add_rdy = 1'b1; out_rdy = 1'b1;
    dat_vld = 1'b0; dat_lst = 1'b0; dat_dat = '0;

    // Reset values.
    tick(); tick();
    chk("rst_cfg_rdy", 32'(cfg_rdy), 1);
    chk("rst_dat_rdy", 32'(dat_rdy), 0);
    chk("rst_add_vld", 32'(add_vld), 0);
    chk("rst_out_vld", 32'(out_vld), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    tick();
    chk("idle_cfg_rdy", 32'(cfg_rdy), 1);
    chk("idle_dat_rdy", 32'(dat_rdy), 1);
    chk("idle_busy", 32'(busy), 0);

    // Basic job: base 0x10, len 4, cycle-exact latency.
    clear_logs();
    cfg(8'h10, 9'd4);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_cfg_rdy", 32'(cfg_rdy), 0);
    chk("t1_add_vld", 32'(add_vld), 1);
    chk("t1_add", 32'(add_add), 'h10);
    chk("t1_add_lst", 32'(add_lst), 0);
    chk("t1_out_vld", 32'(out_vld), 0);
    tick();
    chk("t2_add", 32'(add_add), 'h11);
    chk("t2_out_vld", 32'(out_vld), 0);
    tick();
    chk("t3_out_vld", 32'(out_vld), 1);
    chk("t3_out_dat", 32'(out_dat), 'h4A);
    chk("t3_add", 32'(add_add), 'h12);
    tick();
    chk("t4_add", 32'(add_add), 'h13);
    chk("t4_add_lst", 32'(add_lst), 1);
    tick();
    chk("t5_add_vld", 32'(add_vld), 0);
    chk("t5_busy", 32'(busy), 1);
    chk("t5_done", 32'(done), 0);
    tick();
    chk("t6_out_lst", 32'(out_lst), 1);
    chk("t6_out_dat", 32'(out_dat), 'h49);
    tick();
    chk("t7_done", 32'(done), 1);
    chk("t7_busy", 32'(busy), 0);
    chk("t7_out_vld", 32'(out_vld), 0);
    tick();
    chk("t8_done", 32'(done), 0);
    chk("j1_nadd", add_log.size(), 4);
    chk("j1_nout", out_log.size(), 4);
    chk_add("j1_a0", 0, 8'h10, 1'b0);
    chk_add("j1_a3", 3, 8'h13, 1'b1);
    chk_out("j1_o0", 0, 8'h4A, 1'b0);
    chk_out("j1_o1", 1, 8'h4B, 1'b0);
    chk_out("j1_o2", 2, 8'h48, 1'b0);
    chk_out("j1_o3", 3, 8'h49, 1'b1);

    // Address wrap past 0xFF.
    clear_logs();
    cfg(8'hFE, 9'd4);
    run_until_done(40);
    chk_add("wrap_a0", 0, 8'hFE, 1'b0);
    chk_add("wrap_a1", 1, 8'hFF, 1'b0);
    chk_add("wrap_a2", 2, 8'h00, 1'b0);
    chk_add("wrap_a3", 3, 8'h01, 1'b1);
    chk_out("wrap_o0", 0, 8'hA4, 1'b0);
    chk_out("wrap_o1", 1, 8'hA5, 1'b0);
    chk_out("wrap_o2", 2, 8'h5A, 1'b0);
    chk_out("wrap_o3", 3, 8'h5B, 1'b1);
    tick();

    // Downstream backpressure: credit limits issue to the FIFO depth.
    clear_logs();
    out_rdy = 1'b0;
    cfg(8'h20, 9'd8);
    for (int i = 0; i < 8; i++) tick();
    chk("bp_nadd", add_log.size(), 4);
    chk("bp_add_vld", 32'(add_vld), 0);
    chk("bp_out_vld", 32'(out_vld), 1);
    chk("bp_out_dat", 32'(out_dat), 'h7A);
    chk("bp_busy", 32'(busy), 1);
    out_rdy = 1'b1;
    run_until_done(60);
    chk("bp_nadd_all", add_log.size(), 8);
    chk("bp_nout", out_log.size(), 8);
    chk_out("bp_o0", 0, 8'h7A, 1'b0);
    chk_out("bp_o3", 3, 8'h79, 1'b0);
    chk_out("bp_o4", 4, 8'h7E, 1'b0);
    chk_out("bp_o7", 7, 8'h7D, 1'b1);
    tick();

    // Address-channel stalls: request held stable while RDY is low.
    clear_logs();
    cfg(8'h40, 9'd4);
    add_rdy = 1'b0;
    chk("st_add_a", 32'(add_add), 'h40);
    tick();
    chk("st_vld_held", 32'(add_vld), 1);
    chk("st_add_held", 32'(add_add), 'h40);
    add_rdy = 1'b1;
    tick();
    chk("st_add_b", 32'(add_add), 'h41);
    add_rdy = 1'b0;
    tick();
    chk("st_add_b_held", 32'(add_add), 'h41);
    add_rdy = 1'b1;
    begin
      int n = 0;
      while (!done && n < 40) begin
        tick();
        add_rdy = ~add_rdy;
        n++;
      end
    end
    chk("st_done_seen", 32'(done), 1);
    add_rdy = 1'b1;
    chk("st_nadd", add_log.size(), 4);
    chk_out("st_o0", 0, 8'h1A, 1'b0);
    chk_out("st_o1", 1, 8'h1B, 1'b0);
    chk_out("st_o2", 2, 8'h18, 1'b0);
    chk_out("st_o3", 3, 8'h19, 1'b1);
    tick();

    // Zero-length job.
    clear_logs();
    cfg(8'h33, 9'd0);
    chk("z_done", 32'(done), 1);
    chk("z_add_vld", 32'(add_vld), 0);
    chk("z_busy", 32'(busy), 0);
    tick();
    chk("z_done_clr", 32'(done), 0);
    chk("z_nadd", add_log.size(), 0);

    // Reset in the middle of ISSUE, then a stale data beat, then a clean job.
    clear_logs();
    cfg(8'h50, 9'd8);
    tick(); tick();
    chk("mr_pre_vld", 32'(add_vld), 1);
    rst = 1'b1;
    #1;
    chk("mr_in_rst_vld", 32'(add_vld), 0);
    chk("mr_in_rst_dat_rdy", 32'(dat_rdy), 0);
    chk("mr_in_rst_cfg_rdy", 32'(cfg_rdy), 1);
    tick();
    rst = 1'b0;
    dat_vld = 1'b1; dat_dat = 8'hEE; dat_lst = 1'b1;
    #1;
    chk("mr_idle_busy", 32'(busy), 0);
    chk("mr_idle_out_vld", 32'(out_vld), 0);
    chk("mr_idle_cfg_rdy", 32'(cfg_rdy), 1);
    tick();
    chk("mr_stale_dropped", 32'(out_vld), 0);
    clear_logs();
    cfg(8'h60, 9'd2);
    run_until_done(30);
    chk("mr_nout", out_log.size(), 2);
    chk_add("mr_a1", 1, 8'h61, 1'b1);
    chk_out("mr_o0", 0, 8'h3A, 1'b0);
    chk_out("mr_o1", 1, 8'h3B, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
